// File: rtl/countdown_scheduler.sv
// Round-robin countdown scheduler: switch rising edges queue countdown requests of length
// equal to the switch index; one request is served at a time at TICK_DIV clocks per tick.
module countdown_scheduler #(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic        clk,
  input  logic        rst_btn,
  input  logic [15:0] sw,
  input  logic        pause,
  output logic [3:0]  count,
  output logic [3:0]  grant_idx,
  output logic        busy,
  output logic        done,
  output logic [15:0] pending
);

  localparam logic [15:0] TdivMax = 16'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StCount, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] sw_q;
  logic [15:0] sw_rise;
  logic [15:0] pending_q, pending_d;
  logic [3:0]  count_q, count_d;
  logic [3:0]  grant_q, grant_d;
  logic [3:0]  last_q, last_d;
  logic [15:0] tdiv_q, tdiv_d;

  logic [3:0]  rr_base;
  logic [15:0] rr_rot;
  logic [3:0]  rr_off;
  logic [3:0]  rr_idx;

  assign sw_rise = sw & ~sw_q;

  // Rotate pending so the search origin (last_idx + 1) lands at bit 0, then take the lowest set bit.
  assign rr_base = last_q + 4'd1;
  assign rr_rot  = (pending_q >> rr_base) | (pending_q << (5'd16 - {1'b0, rr_base}));

  always_comb begin
    rr_off = '0;
    for (int i = 15; i >= 0; i--) begin
      if (rr_rot[i]) rr_off = 4'(i);
    end
  end

  assign rr_idx = rr_base + rr_off;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    grant_d   = grant_q;
    last_d    = last_q;
    tdiv_d    = tdiv_q;

    unique case (state_q)
      StIdle: begin
        if (|pending_q) begin
          grant_d = rr_idx;
          state_d = StLoad;
        end
      end
      StLoad: begin
        pending_d[grant_q] = 1'b0;
        last_d             = grant_q;
        count_d            = grant_q;
        tdiv_d             = '0;
        state_d            = StCount;
      end
      StCount: begin
        if (count_q == 4'd0) begin
          state_d = StDone;
        end else if (!pause) begin
          if (tdiv_q == TdivMax) begin
            tdiv_d  = '0;
            count_d = count_q - 4'd1;
          end else begin
            tdiv_d = tdiv_q + 16'd1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A new edge on the bit being cleared in LOAD re-queues it.
    pending_d = pending_d | sw_rise;
  end

  always_ff @(posedge clk) begin
    if (rst_btn) begin
      state_q   <= StIdle;
      sw_q      <= sw;
      pending_q <= '0;
      count_q   <= '0;
      grant_q   <= '0;
      last_q    <= 4'd15;
      tdiv_q    <= '0;
    end else begin
      state_q   <= state_d;
      sw_q      <= sw;
      pending_q <= pending_d;
      count_q   <= count_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      tdiv_q    <= tdiv_d;
    end
  end

  assign count     = count_q;
  assign grant_idx = grant_q;
  assign pending   = pending_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_countdown_scheduler.sv
// Bench for countdown_scheduler: directed latency scenarios plus random stimulus, all checked
// every cycle against a job-level reference model.
module tb_countdown_scheduler;

  localparam int TD = 10;

  localparam int PhIdle  = 0;
  localparam int PhLoad  = 1;
  localparam int PhCount = 2;
  localparam int PhDone  = 3;

  logic        clk = 1'b0;
  logic        rst_btn;
  logic [15:0] sw;
  logic        pause;
  logic [3:0]  count;
  logic [3:0]  grant_idx;
  logic        busy;
  logic        done;
  logic [15:0] pending;

  always #5 clk = ~clk;

  countdown_scheduler #(
    .TICK_DIV(TD)
  ) u_dut (
    .clk      (clk),
    .rst_btn  (rst_btn),
    .sw       (sw),
    .pause    (pause),
    .count    (count),
    .grant_idx(grant_idx),
    .busy     (busy),
    .done     (done),
    .pending  (pending)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          cyc      = 0;

  // Reference model: which job is served, how many unpaused cycles it has run, and the queue.
  int          m_phase;
  int          m_job;
  int          m_last;
  int          m_run;
  int          m_count;
  logic [15:0] m_pend;
  logic [15:0] m_swq;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [15:0] pend, input int last);
    for (int k = 1; k <= 16; k++) begin
      if (pend[(last + k) % 16]) return (last + k) % 16;
    end
    return 0;
  endfunction

  task automatic model_edge();
    logic [15:0] rise;
    if (rst_btn) begin
      m_phase = PhIdle;
      m_job   = 0;
      m_last  = 15;
      m_run   = 0;
      m_count = 0;
      m_pend  = '0;
      m_swq   = sw;
      return;
    end
    rise  = sw & ~m_swq;
    m_swq = sw;
    case (m_phase)
      PhIdle: begin
        if (m_pend != 0) begin
          m_job   = rr_pick(m_pend, m_last);
          m_phase = PhLoad;
        end
      end
      PhLoad: begin
        m_pend[m_job] = 1'b0;
        m_last        = m_job;
        m_run         = 0;
        m_count       = m_job;
        m_phase       = PhCount;
      end
      PhCount: begin
        if (m_count == 0) begin
          m_phase = PhDone;
        end else if (!pause) begin
          m_run++;
          m_count = m_job - m_run / TD;
        end
      end
      default: m_phase = PhIdle;
    endcase
    m_pend = m_pend | rise;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check_eq("count", 32'(count), 32'(m_count));
    check_eq("grant_idx", 32'(grant_idx), 32'(m_job));
    check_eq("busy", 32'(busy), 32'(m_phase != PhIdle));
    check_eq("done", 32'(done), 32'(m_phase == PhDone));
    check_eq("pending", 32'(pending), 32'(m_pend));
  endtask

  // Steps until done is seen; returns cycles since e0, or -1 if the budget runs out.
  task automatic wait_done(input int e0, input int limit, output int dt);
    dt = -1;
    for (int n = 0; n < limit; n++) begin
      step();
      if (done) begin
        dt = cyc - e0;
        return;
      end
    end
  endtask

  task automatic do_reset();
    sw      = '0;
    pause   = 1'b0;
    rst_btn = 1'b1;
    step();
    rst_btn = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int dt;
    int ndone;
    logic [3:0] frozen;

    rst_btn = 1'b1;
    sw      = '0;
    pause   = 1'b0;
    do_reset();
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_grant", 32'(grant_idx), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_pending", 32'(pending), 32'd0);

    // Countdown of 3: done at E2 + 31, idle one cycle later.
    sw[3] = 1'b1;
    step();
    e0 = cyc;
    wait_done(e0, 200, dt);
    check_eq("cd3_done_cycle", 32'(dt), 32'd33);
    step();
    check_eq("cd3_idle", 32'(busy), 32'd0);

    // Countdown of 0: done at E3.
    do_reset();
    sw[0] = 1'b1;
    step();
    e0 = cyc;
    wait_done(e0, 50, dt);
    check_eq("cd0_done_cycle", 32'(dt), 32'd3);
    step();
    check_eq("cd0_idle", 32'(busy), 32'd0);

    // Simultaneous 8 and 3 from last_idx=15: 3 first, then 8.
    do_reset();
    sw[3] = 1'b1;
    sw[8] = 1'b1;
    step();
    e0 = cyc;
    repeat (10) step();
    check_eq("rr_pending_while_3", 32'(pending), 32'h0100);
    check_eq("rr_first_grant", 32'(grant_idx), 32'd3);
    wait_done(e0, 200, dt);
    check_eq("rr_first_done", 32'(dt), 32'd33);
    wait_done(e0, 300, dt);
    check_eq("rr_second_done", 32'(dt), 32'd117);
    check_eq("rr_second_grant", 32'(grant_idx), 32'd8);

    // Pause for 25 cycles mid-countdown delays done by 25.
    do_reset();
    sw[4] = 1'b1;
    step();
    e0 = cyc;
    repeat (10) step();
    frozen = count;
    pause  = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step();
      check_eq("pause_frozen", 32'(count), 32'(frozen));
    end
    pause = 1'b0;
    wait_done(e0, 300, dt);
    check_eq("pause_done_cycle", 32'(dt), 32'd68);

    // Reset mid-countdown with the switch still held.
    do_reset();
    sw[8] = 1'b1;
    step();
    repeat (50) step();
    rst_btn = 1'b1;
    step();
    step();
    rst_btn = 1'b0;
    check_eq("abort_count", 32'(count), 32'd0);
    check_eq("abort_grant", 32'(grant_idx), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_pending", 32'(pending), 32'd0);
    ndone = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (done || busy || pending != 0) ndone++;
    end
    check_eq("abort_no_activity", 32'(ndone), 32'd0);

    // Release and re-press during LOAD re-queues the same index.
    do_reset();
    sw[5] = 1'b1;
    step();
    e0    = cyc;
    sw[5] = 1'b0;
    step();
    sw[5] = 1'b1;
    step();
    check_eq("requeue_pending5", 32'(pending[5]), 32'd1);
    wait_done(e0, 200, dt);
    check_eq("requeue_first_done", 32'(dt), 32'd53);
    wait_done(e0, 300, dt);
    check_eq("requeue_second_done", 32'(dt), 32'd107);
    check_eq("requeue_second_grant", 32'(grant_idx), 32'd5);

    // Random traffic, pauses and occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) sw[$urandom_range(0, 15)] ^= 1'b1;
      pause   = ($urandom_range(0, 7) == 0);
      rst_btn = ($urandom_range(0, 999) == 0);
      step();
    end
    rst_btn = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
